shift_add_multiplier: RTL and testbench

//  Sequential unsigned shift-add multiplier-accumulator: P = M*Q + C.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_datapath.sv | 77 +++++++
 rtl/shift_add_multiplier.sv | 89 ++++++++
 tb/tb_shift_add_multiplier.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier-accumulator.
//   M_W_DEF : default width of multiplicand M and addend C
//   Q_W_DEF : default width of multiplier Q
//   p_width : product width, M_W + Q_W (always wide enough for M*Q + C)
//   state_e : controller states IDLE -> CALC -> ADDC -> IDLE
package mul_pkg;

  localparam int M_W_DEF = 7;
  localparam int Q_W_DEF = 6;

  // (2^M_W-1)*(2^Q_W-1) + (2^M_W-1) = (2^M_W-1)*2^Q_W, which fits in M_W+Q_W bits.
  function automatic int p_width(input int m_w, input int q_w);
    return m_w + q_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADDC = 2'd2
  } state_e;

endpackage

// File: rtl/mul_datapath.sv
// Datapath of the shift-add multiplier-accumulator.
// Holds the operand registers, the {A,Q} shift pair, the conditional adder,
// the step counter and the product register.
//   clk         : clock, rising edge
//   rst_ni      : asynchronous active-low reset, clears every register
//   ld_i        : capture operands, clear A/counter/product
//   step_i      : one multiply step (conditional add, then shift right)
//   addc_i      : form product = {A,Q} + C
//   m_i/q_i/c_i : operand buses, sampled only when ld_i is high
//   last_step_o : current step is the final (Q_W-th) one
//   product_o   : result register, held until the next ld_i
module mul_datapath
  import mul_pkg::*;
#(
  parameter int M_W = M_W_DEF,
  parameter int Q_W = Q_W_DEF,
  parameter int P_W = p_width(M_W, Q_W)
) (
  input  logic           clk,
  input  logic           rst_ni,
  input  logic           ld_i,
  input  logic           step_i,
  input  logic           addc_i,
  input  logic [M_W-1:0] m_i,
  input  logic [Q_W-1:0] q_i,
  input  logic [M_W-1:0] c_i,
  output logic           last_step_o,
  output logic [P_W-1:0] product_o
);

  localparam int CNT_W = $clog2(Q_W + 1);

  logic [M_W-1:0]   m_q;
  logic [M_W-1:0]   c_q;
  logic [M_W:0]     a_q;      // extra MSB catches the adder carry
  logic [Q_W-1:0]   qr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [P_W-1:0]   product_q;
  logic [M_W:0]     sum_d;

  // A is always < 2^M_W after a shift, so A + M never exceeds M_W+1 bits.
  always_comb begin
    sum_d = a_q;
    if (qr_q[0]) begin
      sum_d = a_q + {1'b0, m_q};
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q       <= '0;
      c_q       <= '0;
      a_q       <= '0;
      qr_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (ld_i) begin
      m_q       <= m_i;
      c_q       <= c_i;
      qr_q      <= q_i;
      a_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (step_i) begin
      // {sum,Q} shifted right as one unit; sum LSB enters the Q MSB.
      a_q   <= {1'b0, sum_d[M_W:1]};
      qr_q  <= {sum_d[0], qr_q[Q_W-1:1]};
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (addc_i) begin
      product_q <= {a_q[M_W-1:0], qr_q} + P_W'(c_q);
    end
  end

  assign last_step_o = (cnt_q == CNT_W'(Q_W - 1));
  assign product_o   = product_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier-accumulator: product = M*Q + C, one Q bit
// per cycle. Also reconstructs a dividend from divisor/quotient/remainder.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset; aborts any operation
//   start   : request, honoured only in IDLE
//   M_BUS   : multiplicand, captured on the accepting edge
//   Q_BUS   : multiplier, captured on the accepting edge
//   C_BUS   : addend, captured on the accepting edge
//   busy    : operation in progress (CALC or ADDC)
//   done    : one-cycle pulse, product valid
//   product : M*Q + C, held until the next accepted start
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int M_W = M_W_DEF,
  parameter int Q_W = Q_W_DEF,
  localparam int P_W = p_width(M_W, Q_W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M_W-1:0] M_BUS,
  input  logic [Q_W-1:0] Q_BUS,
  input  logic [M_W-1:0] C_BUS,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product
);

  state_e state_q;
  state_e state_d;
  logic   done_q;
  logic   done_d;
  logic   ld;
  logic   step;
  logic   addc;
  logic   last_step;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_step) state_d = ADDC;
      ADDC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / strobe logic. done is registered so it rises as busy falls.
  always_comb begin
    ld     = (state_q == IDLE) && start;
    step   = (state_q == CALC);
    addc   = (state_q == ADDC);
    busy   = (state_q != IDLE);
    done_d = (state_q == ADDC);
  end

  mul_datapath #(
    .M_W(M_W),
    .Q_W(Q_W),
    .P_W(P_W)
  ) u_datapath (
    .clk        (clk),
    .rst_ni     (rst),
    .ld_i       (ld),
    .step_i     (step),
    .addc_i     (addc),
    .m_i        (M_BUS),
    .q_i        (Q_BUS),
    .c_i        (C_BUS),
    .last_step_o(last_step),
    .product_o  (product)
  );

  assign done = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  localparam int M_W = 7;
  localparam int Q_W = 6;
  localparam int P_W = M_W + Q_W;
  localparam int LAT = Q_W + 2;   // accepted edge -> done, counted in cycles
  localparam int BSY = Q_W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [M_W-1:0] M_BUS;
  logic [Q_W-1:0] Q_BUS;
  logic [M_W-1:0] C_BUS;
  logic           busy;
  logic           done;
  logic [P_W-1:0] product;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  shift_add_multiplier dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .M_BUS  (M_BUS),
    .Q_BUS  (Q_BUS),
    .C_BUS  (C_BUS),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rand_bus();
    M_BUS = M_W'($urandom);
    Q_BUS = Q_W'($urandom);
    C_BUS = M_W'($urandom);
  endtask

  // One full operation; with poke set, start is re-asserted with junk
  // operands on cycles 2..6 of the operation.
  task automatic do_op(input string tag, input int m, input int q, input int c,
                       input bit poke);
    int n;
    int bcnt;
    int exp;
    exp = m * q + c;   // reference model
    @(negedge clk);
    M_BUS = M_W'(m); Q_BUS = Q_W'(q); C_BUS = M_W'(c); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rand_bus();
    n = 1;
    bcnt = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      if (poke && n >= 2 && n <= 6) begin
        start = 1'b1;
        rand_bus();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, n, LAT);
    chk({tag, " busy_cycles"}, bcnt, BSY);
    chk({tag, " product"}, int'(product), exp);
    chk({tag, " busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    chk({tag, " done_one_pulse"}, int'(done), 0);
    chk({tag, " product_held"}, int'(product), exp);
    $display("op %s: M=%0d Q=%0d C=%0d -> product=%0d (expected %0d)",
             tag, m, q, c, product, exp);
  endtask

  initial begin
    int cnt;
    int t0;
    int d, qq, r;
    rst   = 1'b1;
    start = 1'b0;
    rand_bus();
    // Asynchronous reset mid-cycle with random inputs.
    #2 rst = 1'b0;
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset product", int'(product), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_op("basic", 45, 5, 3, 1'b0);
    do_op("max", 127, 63, 127, 1'b0);
    do_op("zero", 0, 0, 0, 1'b0);
    do_op("q0", 99, 0, 17, 1'b0);
    do_op("m0", 0, 55, 88, 1'b0);
    do_op("ignore_start", 21, 37, 9, 1'b1);

    // Reset aborts an operation in flight.
    @(negedge clk);
    M_BUS = 7'd100; Q_BUS = 6'd50; C_BUS = 7'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort product", int'(product), 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort no_done", cnt, 0);
    do_op("after_abort", 10, 10, 0, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    M_BUS = 7'd3; Q_BUS = 6'd4; C_BUS = 7'd1; start = 1'b1;
    @(negedge clk);
    M_BUS = 7'd6; Q_BUS = 6'd7; C_BUS = 7'd2;
    cnt = 0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    t0 = cyc;
    chk("b2b first product", int'(product), 13);
    @(negedge clk);
    chk("b2b done_drops", int'(done), 0);
    chk("b2b product_cleared", int'(product), 0);
    cnt = 0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    chk("b2b spacing", cyc - t0, LAT);
    chk("b2b second product", int'(product), 44);
    $display("b2b: second product=%0d spacing=%0d", product, cyc - t0);

    // Random M*Q+C.
    for (int i = 0; i < 15; i++) begin
      do_op("rand", int'($urandom_range(127)), int'($urandom_range(63)),
            int'($urandom_range(127)), 1'b0);
    end

    // Divider round trip: divisor*quotient + remainder == dividend.
    for (int i = 0; i < 15; i++) begin
      d  = int'($urandom_range(127, 1));
      qq = int'($urandom_range(63));
      r  = int'($urandom_range(d - 1));
      do_op("roundtrip", d, qq, r, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
